// File: rtl/fp_round_pkg.sv
// rtl/fp_round_pkg.sv - rounding-mode encodings and default widths for the FP rounding path
package fp_round_pkg;

    typedef enum logic [1:0] {
        RM_ZERO = 2'b00,
        RM_NEG  = 2'b01,
        RM_POS  = 2'b10,
        RM_NEAR = 2'b11
    } round_mode_t;

    localparam int DEF_SW = 23;
    localparam int DEF_RW = 23;
    localparam int DEF_EW = 8;

endpackage

// File: rtl/round_flag_gen.sv
// rtl/round_flag_gen.sv - combinational round-increment decision from guard/sticky/lsb, sign and mode
module round_flag_gen
    import fp_round_pkg::*;
#(
    parameter int RW = DEF_RW
) (
    input  logic [RW-1:0] round_bits,
    input  logic          lsb,
    input  logic          sign,
    input  round_mode_t   mode,
    output logic          flag,
    output logic          inexact
);

    logic guard;
    logic sticky;
    logic any_tail;

    assign guard    = round_bits[RW-1];
    assign sticky   = |round_bits[RW-2:0];
    assign any_tail = guard | sticky;
    assign inexact  = any_tail;

    always_comb begin
        flag = 1'b0;
        unique case (mode)
            RM_ZERO: flag = 1'b0;
            RM_NEG:  flag = sign & any_tail;
            RM_POS:  flag = ~sign & any_tail;
            RM_NEAR: flag = guard & (sticky | lsb);
            default: flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_stage_pipe.sv
// rtl/round_stage_pipe.sv - two-stage round/renormalise pipeline with valid/ready backpressure
module round_stage_pipe
    import fp_round_pkg::*;
#(
    parameter int SW = DEF_SW,
    parameter int RW = DEF_RW,
    parameter int EW = DEF_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [SW:0]   sgf_i,
    input  logic [RW-1:0] round_bits_i,
    input  logic [EW-1:0] exp_i,
    input  logic          sign_i,
    input  logic [1:0]    round_mode_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [SW-1:0] frac_o,
    output logic [EW-1:0] exp_o,
    output logic          sign_o,
    output logic          round_flag_o,
    output logic          inexact_o,
    output logic          ovf_o
);

    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};

    logic          s1_valid;
    logic [SW:0]   s1_sgf;
    logic [EW-1:0] s1_exp;
    logic          s1_sign;
    logic          s1_flag;
    logic          s1_inexact;
    logic          s1_bypass;

    logic          s1_load;
    logic          s2_load;
    logic          in_bypass;
    logic          dec_flag;
    logic          dec_inexact;

    logic [SW:0]   low_sum;
    logic          carry;
    logic [EW-1:0] exp_rnd;
    logic          ovf_next;
    logic [SW-1:0] frac_next;

    assign s2_load    = ~out_valid_o | out_ready_i;
    assign s1_load    = ~s1_valid | s2_load;
    assign in_ready_o = ~rst & s1_load;

    assign in_bypass = (exp_i == EXP_MAX);

    round_flag_gen #(
        .RW(RW)
    ) u_flag_gen (
        .round_bits (round_bits_i),
        .lsb        (sgf_i[0]),
        .sign       (sign_i),
        .mode       (round_mode_t'(round_mode_i)),
        .flag       (dec_flag),
        .inexact    (dec_inexact)
    );

    // Carry out of the fraction only leaves the significand when the hidden bit was set.
    assign low_sum   = {1'b0, s1_sgf[SW-1:0]} + {{SW{1'b0}}, s1_flag};
    assign carry     = low_sum[SW] & s1_sgf[SW];
    assign exp_rnd   = carry ? (s1_exp + EXP_ONE) : s1_exp;
    assign ovf_next  = (exp_rnd == EXP_MAX) & ~s1_bypass;
    assign frac_next = (carry | ovf_next) ? '0 : low_sum[SW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sgf     <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_flag    <= 1'b0;
            s1_inexact <= 1'b0;
            s1_bypass  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sgf     <= sgf_i;
                s1_exp     <= exp_i;
                s1_sign    <= sign_i;
                s1_flag    <= dec_flag & ~in_bypass;
                s1_inexact <= dec_inexact & ~in_bypass;
                s1_bypass  <= in_bypass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            frac_o       <= '0;
            exp_o        <= '0;
            sign_o       <= 1'b0;
            round_flag_o <= 1'b0;
            inexact_o    <= 1'b0;
            ovf_o        <= 1'b0;
        end else if (s2_load) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                frac_o       <= frac_next;
                exp_o        <= exp_rnd;
                sign_o       <= s1_sign;
                round_flag_o <= s1_flag;
                inexact_o    <= s1_inexact;
                ovf_o        <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_round_stage_pipe.sv
// tb/tb_round_stage_pipe.sv - scoreboard bench for round_stage_pipe with an arithmetic rounding model
module tb_round_stage_pipe;
    import fp_round_pkg::*;

    localparam int SW = 23;
    localparam int RW = 23;
    localparam int EW = 8;

    typedef struct packed {
        logic [SW-1:0] frac;
        logic [EW-1:0] exp;
        logic          sign;
        logic          flag;
        logic          inex;
        logic          ovf;
    } res_t;

    typedef struct packed {
        logic [SW:0]   sgf;
        logic [RW-1:0] rb;
        logic [EW-1:0] exp;
        logic          sign;
        logic [1:0]    mode;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [SW:0]   sgf_i = '0;
    logic [RW-1:0] round_bits_i = '0;
    logic [EW-1:0] exp_i = '0;
    logic          sign_i = 1'b0;
    logic [1:0]    round_mode_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [SW-1:0] frac_o;
    logic [EW-1:0] exp_o;
    logic          sign_o;
    logic          round_flag_o;
    logic          inexact_o;
    logic          ovf_o;

    always #5 clk = ~clk;

    round_stage_pipe #(.SW(SW), .RW(RW), .EW(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .sgf_i        (sgf_i),
        .round_bits_i (round_bits_i),
        .exp_i        (exp_i),
        .sign_i       (sign_i),
        .round_mode_i (round_mode_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .frac_o       (frac_o),
        .exp_o        (exp_o),
        .sign_o       (sign_o),
        .round_flag_o (round_flag_o),
        .inexact_o    (inexact_o),
        .ovf_o        (ovf_o)
    );

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [SW:0] sgf, input logic [RW-1:0] rb,
                                 input logic [EW-1:0] e, input logic s, input logic [1:0] m);
        beat_t b;
        b.sgf = sgf; b.rb = rb; b.exp = e; b.sign = s; b.mode = m;
        return b;
    endfunction

    function automatic res_t rs(input logic [SW-1:0] f, input logic [EW-1:0] e, input logic s,
                                input logic fl, input logic ix, input logic ov);
        res_t r;
        r.frac = f; r.exp = e; r.sign = s; r.flag = fl; r.inex = ix; r.ovf = ov;
        return r;
    endfunction

    // Reference: treat the tail as a fraction of one ulp and round the integer significand.
    function automatic res_t model(input beat_t b);
        res_t   o;
        longint tail = longint'(b.rb);
        longint half = longint'(1) << (RW - 1);
        longint r;
        int     e;
        bit     inc = 0;
        bit     byp = (int'(b.exp) == (1 << EW) - 1);
        if (!byp) begin
            case (b.mode)
                2'b00: inc = 0;
                2'b01: inc = b.sign && tail != 0;
                2'b10: inc = !b.sign && tail != 0;
                default: inc = (tail > half) || (tail == half && b.sgf[0]);
            endcase
        end
        e = int'(b.exp);
        r = longint'(b.sgf) + (inc ? 1 : 0);
        if (r >= (longint'(1) << (SW + 1))) begin
            e = e + 1;
            o.frac = '0;
        end else begin
            o.frac = SW'(r % (longint'(1) << SW));
        end
        o.ovf = !byp && (e == (1 << EW) - 1);
        if (o.ovf) o.frac = '0;
        o.exp  = EW'(e);
        o.sign = b.sign;
        o.flag = inc;
        o.inex = !byp && tail != 0;
        return o;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        case ($urandom_range(0, 5))
            0: b.sgf = '1;
            1: b.sgf = {1'b1, {SW{1'b0}}};
            default: b.sgf = {1'b1, SW'($urandom)};
        endcase
        case ($urandom_range(0, 4))
            0: b.rb = '0;
            1: b.rb = RW'(1) << (RW - 1);
            2: b.rb = RW'(1);
            default: b.rb = RW'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0: b.exp = '1;
            1: b.exp = 8'hFE;
            default: b.exp = EW'($urandom);
        endcase
        b.sign = 1'($urandom);
        b.mode = 2'($urandom);
        return b;
    endfunction

    task automatic send(input beat_t b, input res_t r);
        int n = 0;
        sgf_i = b.sgf; round_bits_i = b.rb; exp_i = b.exp;
        sign_i = b.sign; round_mode_i = b.mode; in_valid_i = 1'b1;
        @(negedge clk);
        while (!in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    res_t cur;
    res_t held;
    bit   hold = 0;
    assign cur = {frac_o, exp_o, sign_o, round_flag_o, inexact_o, ovf_o};

    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) check("stall_hold", 64'({out_valid_o, cur}), 64'({1'b1, held}));
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: got %h expected none", cur);
                end else begin
                    check("result", 64'(cur), 64'(exp_q.pop_front()));
                end
                hold = 0;
            end else if (out_valid_o) begin
                hold = 1;
                held = cur;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({out_valid_o, cur, in_ready_o}), 64'(0));
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(in_ready_o), 64'(1));

        send(mk(24'h800001, 23'h400000, 8'h7F, 1'b0, RM_NEAR), rs(23'h000002, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0));
        check("latency_cycle1", 64'(out_valid_o), 64'(0));
        @(posedge clk);
        #1;
        check("latency_cycle2", 64'(out_valid_o), 64'(1));

        send(mk(24'h800000, 23'h400000, 8'h7F, 1'b0, RM_NEAR), rs(23'h000000, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h400001, 8'h7F, 1'b1, RM_NEAR), rs(23'h000001, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h000001, 8'h7F, 1'b0, RM_POS),  rs(23'h000001, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h000001, 8'h7F, 1'b1, RM_POS),  rs(23'h000000, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h000001, 8'h7F, 1'b1, RM_NEG),  rs(23'h000001, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h000001, 8'h7F, 1'b0, RM_NEG),  rs(23'h000000, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h7FFFFF, 8'h7F, 1'b0, RM_ZERO), rs(23'h000000, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0));
        send(mk(24'h800000, 23'h7FFFFF, 8'h7F, 1'b1, RM_ZERO), rs(23'h000000, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0));
        send(mk(24'hFFFFFF, 23'h000005, 8'h7F, 1'b0, RM_POS),  rs(23'h000000, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0));
        send(mk(24'hFFFFFF, 23'h000005, 8'hFE, 1'b0, RM_POS),  rs(23'h000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(24'hFFFFFF, 23'h000005, 8'hFF, 1'b0, RM_POS),  rs(23'h7FFFFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    beat_t b = rand_beat();
                    send(b, model(b));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready_i = 1'b0;
                @(negedge clk);
                check("stall_in_ready", 64'({out_valid_o, in_ready_o}), 64'({1'b1, 1'b0}));
                @(posedge clk);
                repeat (2) @(posedge clk);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain();

        out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            beat_t b = rand_beat();
            send(b, model(b));
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("in_ready_in_reset", 64'(in_ready_o), 64'(0));
        @(posedge clk);
        #1;
        check("reset_flush", 64'({out_valid_o, cur}), 64'(0));
        rst = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check("ready_after_midreset", 64'(in_ready_o), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        check("no_ghost_beats", 64'(out_valid_o), 64'(0));

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    beat_t b = rand_beat();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(b, model(b));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready_i = ($urandom_range(0, 3) != 0);
                end
                out_ready_i = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
